// File: rtl/cajero_pkg.sv
// Shared definitions for the ATM transaction sequencer: state encoding,
// BCD digit constants, digit cap and transaction type encodings.
package cajero_pkg;

    typedef enum logic [3:0] {
        IDLE      = 4'b0001,
        CAPTURA   = 4'b0010,
        VERIFICAR = 4'b0100,
        RESULTADO = 4'b1000
    } estado_t;

    localparam logic [3:0] CERO   = 4'd0;
    localparam logic [3:0] UNO    = 4'd1;
    localparam logic [3:0] DOS    = 4'd2;
    localparam logic [3:0] TRES   = 4'd3;
    localparam logic [3:0] CUATRO = 4'd4;
    localparam logic [3:0] CINCO  = 4'd5;
    localparam logic [3:0] SEIS   = 4'd6;
    localparam logic [3:0] SIETE  = 4'd7;
    localparam logic [3:0] OCHO   = 4'd8;
    localparam logic [3:0] NUEVE  = 4'd9;
    localparam logic [3:0] VACIO  = 4'hF;

    localparam int MAX_DIGITOS = 8;

    localparam logic DEPOSITO = 1'b0;
    localparam logic RETIRO   = 1'b1;

endpackage

// File: rtl/cajero_transacciones_acumulador_monto.sv
// Decimal amount capture: accumulates BCD digits most significant first,
// discarding non-decimal codes and anything past the eighth digit.
module acumulador_monto
    import cajero_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        i_limpiar,
    input  logic        i_digito_stb,
    input  logic [3:0]  i_digito,
    output logic [31:0] o_monto,
    output logic [3:0]  o_cuenta,
    output logic        o_acepta
);

    logic [31:0] r_monto;
    logic [3:0]  r_cuenta;
    logic        w_acepta;

    assign w_acepta = i_digito_stb && (i_digito <= NUEVE) && (r_cuenta < 4'(MAX_DIGITOS));

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset || i_limpiar) begin
            r_monto  <= '0;
            r_cuenta <= '0;
        end else if (w_acepta) begin
            r_monto  <= r_monto * 32'd10 + {28'd0, i_digito};
            r_cuenta <= r_cuenta + 4'd1;
        end
    end

    assign o_monto  = r_monto;
    assign o_cuenta = r_cuenta;
    assign o_acepta = w_acepta;

endmodule

// File: rtl/cajero_transacciones.sv
// ATM transaction sequencer and balance owner. Defining CAJERO_LIMITE_RETIRO_EN
// adds a cumulative withdrawal limit that rejects with limite_excedido.
module cajero_transacciones
    import cajero_pkg::*;
#(
    parameter logic [31:0] BALANCE_INIT   = 32'd10000,
    parameter int          TIMEOUT_CYCLES = 1000,
    parameter logic [31:0] LIMITE_RETIRO  = 32'd5000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        sesion_inicio,
    input  logic        tipo_trans,
    input  logic        digito_stb,
    input  logic [3:0]  digito,
    input  logic        monto_stb,
    input  logic        cancelar,
    output logic [31:0] balance_actualizado,
    output logic        balance_valido,
    output logic        entregar_dinero,
    output logic        fondos_insuficientes,
    output logic        deposito_rechazado,
    output logic        limite_excedido,
    output logic        ocupado,
    output logic        sesion_fin
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    estado_t     r_estado, w_estado_sig;
    logic [TW-1:0] r_timeout, w_timeout_sig;
    logic        r_tipo;
    logic [31:0] r_balance;
    logic        r_valido, r_entregar, r_fondos, r_rechazo, r_ocupado, r_fin;
    logic        w_abort, w_limpiar;

    logic [31:0] w_monto;
    logic [3:0]  w_cuenta;
    logic        w_acepta;
    logic [32:0] w_suma;
    logic        w_verifica, w_limite_excede;
    logic        w_commit_retiro, w_rechazo_fondos, w_commit_dep, w_rechazo_dep;

    acumulador_monto u_acumulador (
        .clock        (clock),
        .reset        (reset),
        .i_limpiar    (w_limpiar),
        .i_digito_stb (digito_stb && (r_estado == CAPTURA)),
        .i_digito     (digito),
        .o_monto      (w_monto),
        .o_cuenta     (w_cuenta),
        .o_acepta     (w_acepta)
    );

    // NOTE: every signal driven here gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_estado_sig  = r_estado;
        w_timeout_sig = '0;
        w_abort       = 1'b0;
        w_limpiar     = 1'b0;
        unique case (r_estado)
            IDLE: begin
                if (sesion_inicio) begin
                    w_estado_sig = CAPTURA;
                    w_limpiar    = 1'b1;
                end
            end
            CAPTURA: begin
                if (cancelar) begin
                    w_estado_sig = IDLE;
                    w_abort      = 1'b1;
                end else if (monto_stb && ((w_cuenta != 4'd0) || w_acepta)) begin
                    w_estado_sig = VERIFICAR;
                end else if (digito_stb) begin
                    w_timeout_sig = '0;
                end else if (r_timeout == TW'(TIMEOUT_CYCLES - 1)) begin
                    w_estado_sig = IDLE;
                    w_abort      = 1'b1;
                end else begin
                    w_timeout_sig = r_timeout + 1'b1;
                end
            end
            VERIFICAR: begin
                if (cancelar) begin
                    w_estado_sig = IDLE;
                    w_abort      = 1'b1;
                end else begin
                    w_estado_sig = RESULTADO;
                end
            end
            RESULTADO: w_estado_sig = IDLE;
            default:   w_estado_sig = IDLE;
        endcase
    end

    // Outcome of the check made while in VERIFICAR; the limit has priority.
    assign w_suma           = {1'b0, r_balance} + {1'b0, w_monto};
    assign w_verifica       = (r_estado == VERIFICAR) && !cancelar;
    assign w_rechazo_fondos = w_verifica && (r_tipo == RETIRO) && !w_limite_excede && (w_monto > r_balance);
    assign w_commit_retiro  = w_verifica && (r_tipo == RETIRO) && !w_limite_excede && (w_monto <= r_balance);
    assign w_rechazo_dep    = w_verifica && (r_tipo == DEPOSITO) && w_suma[32];
    assign w_commit_dep     = w_verifica && (r_tipo == DEPOSITO) && !w_suma[32];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado   <= IDLE;
            r_timeout  <= '0;
            r_tipo     <= DEPOSITO;
            r_balance  <= BALANCE_INIT;
            r_valido   <= 1'b0;
            r_entregar <= 1'b0;
            r_fondos   <= 1'b0;
            r_rechazo  <= 1'b0;
            r_ocupado  <= 1'b0;
            r_fin      <= 1'b0;
        end else begin
            r_estado   <= w_estado_sig;
            r_timeout  <= w_timeout_sig;
            r_ocupado  <= (w_estado_sig != IDLE);
            r_fin      <= w_abort || w_verifica;
            r_valido   <= w_commit_retiro || w_commit_dep;
            r_entregar <= w_commit_retiro;
            r_fondos   <= w_rechazo_fondos;
            r_rechazo  <= w_rechazo_dep;
            if (r_estado == IDLE && sesion_inicio)
                r_tipo <= tipo_trans;
            if (w_commit_retiro)
                r_balance <= r_balance - w_monto;
            else if (w_commit_dep)
                r_balance <= w_suma[31:0];
        end
    end

`ifdef CAJERO_LIMITE_RETIRO_EN
    logic [31:0] r_total;
    logic [32:0] w_total_sig;
    logic        r_limite;

    assign w_total_sig     = {1'b0, r_total} + {1'b0, w_monto};
    assign w_limite_excede = (w_total_sig > {1'b0, LIMITE_RETIRO});

    always_ff @(posedge clock) begin
        if (reset) begin
            r_total  <= '0;
            r_limite <= 1'b0;
        end else begin
            r_limite <= w_verifica && (r_tipo == RETIRO) && w_limite_excede;
            if (w_commit_retiro)
                r_total <= w_total_sig[31:0];
        end
    end

    assign limite_excedido = r_limite;
`else
    assign w_limite_excede = 1'b0;
    assign limite_excedido = 1'b0;
`endif

    assign balance_actualizado  = r_balance;
    assign balance_valido       = r_valido;
    assign entregar_dinero      = r_entregar;
    assign fondos_insuficientes = r_fondos;
    assign deposito_rechazado   = r_rechazo;
    assign ocupado              = r_ocupado;
    assign sesion_fin           = r_fin;

endmodule

// File: tb/tb_cajero_transacciones.sv
// Self-checking bench for cajero_transacciones: directed scenarios plus random
// sessions, compared against an arithmetic model of balance and outcomes.
module tb_cajero_transacciones;

    localparam int     TIMEOUT  = 1000;
    localparam longint BAL_INIT = 10000;
    localparam longint LIMITE   = 5000;

    logic        clock = 1'b0;
    logic        reset;
    logic        sesion_inicio, tipo_trans, digito_stb, monto_stb, cancelar;
    logic [3:0]  digito;
    logic [31:0] balance_actualizado;
    logic        balance_valido, entregar_dinero, fondos_insuficientes;
    logic        deposito_rechazado, limite_excedido, ocupado, sesion_fin;

    int          n_checks = 0;
    int          n_errors = 0;
    longint      m_bal, m_total;
    logic [3:0]  q_dig[$];

    cajero_transacciones #(
        .BALANCE_INIT   (32'd10000),
        .TIMEOUT_CYCLES (TIMEOUT),
        .LIMITE_RETIRO  (32'd5000)
    ) dut (
        .clock                (clock),
        .reset                (reset),
        .sesion_inicio        (sesion_inicio),
        .tipo_trans           (tipo_trans),
        .digito_stb           (digito_stb),
        .digito               (digito),
        .monto_stb            (monto_stb),
        .cancelar             (cancelar),
        .balance_actualizado  (balance_actualizado),
        .balance_valido       (balance_valido),
        .entregar_dinero      (entregar_dinero),
        .fondos_insuficientes (fondos_insuficientes),
        .deposito_rechazado   (deposito_rechazado),
        .limite_excedido      (limite_excedido),
        .ocupado              (ocupado),
        .sesion_fin           (sesion_fin)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {valido, entregar, fondos, rechazo, limite, fin}
    function automatic logic [5:0] pulsos();
        return {balance_valido, entregar_dinero, fondos_insuficientes,
                deposito_rechazado, limite_excedido, sesion_fin};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic longint modelo_monto();
        longint m = 0;
        int     c = 0;
        foreach (q_dig[i])
            if (q_dig[i] <= 4'd9 && c < 8) begin
                m = m * 10 + longint'(q_dig[i]);
                c++;
            end
        return m;
    endfunction

    task automatic cargar_numero(input longint v);
        q_dig.delete();
        if (v == 0) q_dig.push_back(4'd0);
        while (v > 0) begin
            q_dig.push_front(4'(v % 10));
            v = v / 10;
        end
    endtask

    task automatic sesion(input bit tipo, input bit mismo_ciclo, input string tag);
        longint      m, viejo;
        logic [5:0]  esp;
        bit          lim;
        m     = modelo_monto();
        viejo = m_bal;
        esp   = 6'b000001;
        lim   = 1'b0;
`ifdef CAJERO_LIMITE_RETIRO_EN
        lim = tipo && (m_total + m > LIMITE);
`endif
        if (tipo) begin
            if (lim) esp[1] = 1'b1;
            else if (m > m_bal) esp[3] = 1'b1;
            else begin
                m_bal   -= m;
                m_total += m;
                esp[5] = 1'b1;
                esp[4] = 1'b1;
            end
        end else begin
            if (m_bal + m > 64'hFFFF_FFFF) esp[2] = 1'b1;
            else begin
                m_bal += m;
                esp[5] = 1'b1;
            end
        end

        sesion_inicio = 1'b1;
        tipo_trans    = tipo;
        tick();
        sesion_inicio = 1'b0;
        check($sformatf("%s.ocupado_ini", tag), ocupado, 1'b1);
        foreach (q_dig[i]) begin
            digito_stb = 1'b1;
            digito     = q_dig[i];
            if (mismo_ciclo && i == q_dig.size() - 1) monto_stb = 1'b1;
            tick();
            digito_stb = 1'b0;
            monto_stb  = 1'b0;
        end
        if (!mismo_ciclo) begin
            monto_stb = 1'b1;
            tick();
            monto_stb = 1'b0;
        end
        check($sformatf("%s.pulsos_verif", tag), pulsos(), 6'b0);
        check($sformatf("%s.balance_verif", tag), balance_actualizado, viejo[31:0]);
        tick();
        check($sformatf("%s.pulsos", tag), pulsos(), esp);
        check($sformatf("%s.balance", tag), balance_actualizado, m_bal[31:0]);
        tick();
        check($sformatf("%s.ocupado_fin", tag), ocupado, 1'b0);
        check($sformatf("%s.pulsos_idle", tag), pulsos(), 6'b0);
    endtask

    initial begin
        int n;
        longint d;
        reset = 1'b1;
        sesion_inicio = 1'b0; tipo_trans = 1'b0; digito_stb = 1'b0;
        digito = 4'd0; monto_stb = 1'b0; cancelar = 1'b0;
        m_bal = BAL_INIT;
        m_total = 0;
        tick(); tick();
        reset = 1'b0;
        check("reset.balance", balance_actualizado, 32'd10000);
        check("reset.pulsos", pulsos(), 6'b0);
        check("reset.ocupado", ocupado, 1'b0);

        // Withdrawal 2500 -> 7500
        cargar_numero(2500);
        sesion(1'b1, 1'b0, "retiro2500");

        // Reset in the middle of capture restores the initial balance
        sesion_inicio = 1'b1; tipo_trans = 1'b1; tick(); sesion_inicio = 1'b0;
        digito_stb = 1'b1; digito = 4'd3; tick(); digito_stb = 1'b0;
        reset = 1'b1; tick(); reset = 1'b0;
        m_bal = BAL_INIT; m_total = 0;
        check("reset_medio.balance", balance_actualizado, 32'd10000);
        check("reset_medio.ocupado", ocupado, 1'b0);
        check("reset_medio.pulsos", pulsos(), 6'b0);

        // Withdrawal larger than the balance
        cargar_numero(12000);
        sesion(1'b1, 1'b0, "retiro12000");

        // Cumulative limit sequence
        cargar_numero(3000);
        sesion(1'b1, 1'b0, "retiro3000");
        cargar_numero(2500);
        sesion(1'b1, 1'b1, "retiro2500b");

        // Digit handling: invalid code and digits past the eighth are ignored
        q_dig = '{4'd1, 4'hF, 4'd2};
        for (int i = 0; i < 9; i++) q_dig.push_back(4'd9);
        check("digitos.modelo", modelo_monto(), 64'd12999999);
        sesion(1'b0, 1'b1, "digitos");

        // monto_stb with no digits is ignored; then cancel
        sesion_inicio = 1'b1; tipo_trans = 1'b0; tick(); sesion_inicio = 1'b0;
        monto_stb = 1'b1; tick(); monto_stb = 1'b0;
        tick();
        check("sin_digitos.pulsos", pulsos(), 6'b0);
        tick();
        check("sin_digitos.ocupado", ocupado, 1'b1);
        cancelar = 1'b1; tick(); cancelar = 1'b0;
        check("cancel.pulsos", pulsos(), 6'b000001);
        check("cancel.ocupado", ocupado, 1'b0);

        // cancelar in the same cycle as monto_stb wins
        sesion_inicio = 1'b1; tipo_trans = 1'b1; tick(); sesion_inicio = 1'b0;
        digito_stb = 1'b1; digito = 4'd1; tick();
        digito = 4'd5; monto_stb = 1'b1; cancelar = 1'b1; tick();
        digito_stb = 1'b0; monto_stb = 1'b0; cancelar = 1'b0;
        check("cancel_monto.pulsos", pulsos(), 6'b000001);
        check("cancel_monto.ocupado", ocupado, 1'b0);
        tick();
        check("cancel_monto.pulsos2", pulsos(), 6'b0);
        check("cancel_monto.balance", balance_actualizado, m_bal[31:0]);

        // Timeout with no further digits
        sesion_inicio = 1'b1; tipo_trans = 1'b0; tick(); sesion_inicio = 1'b0;
        digito_stb = 1'b1; digito = 4'd7; tick(); digito_stb = 1'b0;
        n = 0;
        while (!sesion_fin && n < TIMEOUT + 100) begin
            tick();
            n++;
        end
        check("timeout.ventana", (n >= TIMEOUT - 1) && (n <= TIMEOUT + 1), 1'b1);
        check("timeout.pulsos", pulsos(), 6'b000001);
        check("timeout.ocupado", ocupado, 1'b0);
        check("timeout.balance", balance_actualizado, m_bal[31:0]);

        // Random sessions
        for (int s = 0; s < 25; s++) begin
            int nd;
            nd = $urandom_range(1, 6);
            q_dig.delete();
            q_dig.push_back(4'($urandom_range(0, 9)));
            for (int k = 1; k < nd; k++)
                if ($urandom_range(0, 5) == 0) q_dig.push_back(4'($urandom_range(10, 15)));
                else q_dig.push_back(4'($urandom_range(0, 9)));
            sesion(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $sformatf("rnd%0d", s));
        end

        // Fill the balance up to 32'hFFFF_FF00 with deposits
        while (m_bal < 64'hFFFF_FF00) begin
            d = 64'hFFFF_FF00 - m_bal;
            if (d > 99999999) d = 99999999;
            cargar_numero(d);
            sesion(1'b0, 1'b0, "llenado");
        end
        cargar_numero(500);
        sesion(1'b0, 1'b0, "desborde");
        cargar_numero(100);
        sesion(1'b0, 1'b1, "deposito100");
        check("final.balance", balance_actualizado, 32'hFFFF_FF64);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
